// File: rtl/matrix_pkg.sv
// Shared defaults, FSM encoding and element addressing for the matrix MAC engine.
// Elements are stored row-major in a MAX_DIM x MAX_DIM grid regardless of the active size.
package matrix_pkg;

  localparam int MAX_DIM_DEF = 5;
  localparam int ELEM_W_DEF  = 8;
  localparam int ACC_W_DEF   = 2 * ELEM_W_DEF + $clog2(MAX_DIM_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_MAC   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int elem_idx(input int r, input int c, input int dim);
    return r * dim + c;
  endfunction

endpackage

// File: rtl/matrix_mac_cell.sv
// One multiply-accumulate step plus the truncate/saturate clamp for the output element.
// Purely combinational; the engine owns the accumulator register.
module matrix_mac_cell
  import matrix_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              sat,
  output logic [ACC_W-1:0]  acc_sum,
  output logic [ELEM_W-1:0] result
);

  logic [2*ELEM_W-1:0] prod;

  assign prod    = (2*ELEM_W)'(a) * (2*ELEM_W)'(b);
  assign acc_sum = acc_in + ACC_W'(prod);

  // Any bit above the element width means the sum does not fit.
  assign result = (sat && (|acc_sum[ACC_W-1:ELEM_W])) ? {ELEM_W{1'b1}}
                                                      : acc_sum[ELEM_W-1:0];

endmodule

// File: rtl/matrix_mac_engine.sv
// Sequential matrix multiplier: validates dimensions, then computes C = A x B
// with one product per cycle, writing each element as its dot product completes.
module matrix_mac_engine
  import matrix_pkg::*;
#(
  parameter int MAX_DIM = MAX_DIM_DEF,
  parameter int ELEM_W  = ELEM_W_DEF,
  parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                sat,
  input  logic [DIM_W-1:0]                    a_m,
  input  logic [DIM_W-1:0]                    a_n,
  input  logic [DIM_W-1:0]                    b_m,
  input  logic [DIM_W-1:0]                    b_n,
  input  logic [2*MAX_DIM*MAX_DIM*ELEM_W-1:0] matrices_in,
  output logic                                busy,
  output logic                                done,
  output logic                                valid,
  output logic                                error,
  output logic [DIM_W-1:0]                    c_m,
  output logic [DIM_W-1:0]                    c_n,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matrices_out
);

  localparam int ACC_W  = 2 * ELEM_W + $clog2(MAX_DIM);
  localparam int NUM_EL = MAX_DIM * MAX_DIM;
  localparam int MAT_W  = NUM_EL * ELEM_W;
  localparam int IDX_W  = $clog2(NUM_EL);
  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  state_t state_reg, state_next;

  logic [MAT_W-1:0]  a_reg, b_reg;
  logic              sat_reg;
  logic [DIM_W-1:0]  a_m_reg, a_n_reg, b_m_reg, b_n_reg;
  logic [DIM_W-1:0]  i_reg, j_reg, k_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic              busy_reg, done_reg, valid_reg, error_reg;
  logic [DIM_W-1:0]  c_m_reg, c_n_reg;
  logic [ELEM_W-1:0] c_arr_reg [NUM_EL];

  logic [ELEM_W-1:0] a_arr [NUM_EL];
  logic [ELEM_W-1:0] b_arr [NUM_EL];
  logic [IDX_W-1:0]  a_idx, b_idx, c_idx;
  logic [ACC_W-1:0]  acc_sum;
  logic [ELEM_W-1:0] c_elem;
  logic              dim_bad, last_k, last_j, last_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_EL; gi++) begin : g_elems
      assign a_arr[gi] = a_reg[gi*ELEM_W +: ELEM_W];
      assign b_arr[gi] = b_reg[gi*ELEM_W +: ELEM_W];
      assign matrices_out[gi*ELEM_W +: ELEM_W] = c_arr_reg[gi];
    end
  endgenerate

  assign dim_bad = (a_m_reg == '0) || (a_n_reg == '0) || (b_m_reg == '0) || (b_n_reg == '0) ||
                   (a_m_reg > DIM_MAX) || (a_n_reg > DIM_MAX) ||
                   (b_m_reg > DIM_MAX) || (b_n_reg > DIM_MAX) ||
                   (a_n_reg != b_m_reg);

  assign last_k = (k_reg == a_n_reg - DIM_ONE);
  assign last_j = (j_reg == b_n_reg - DIM_ONE);
  assign last_i = (i_reg == a_m_reg - DIM_ONE);

  assign a_idx = IDX_W'(elem_idx(int'(i_reg), int'(k_reg), MAX_DIM));
  assign b_idx = IDX_W'(elem_idx(int'(k_reg), int'(j_reg), MAX_DIM));
  assign c_idx = IDX_W'(elem_idx(int'(i_reg), int'(j_reg), MAX_DIM));

  matrix_mac_cell #(
    .ELEM_W (ELEM_W),
    .ACC_W  (ACC_W)
  ) u_mac_cell (
    .a       (a_arr[a_idx]),
    .b       (b_arr[b_idx]),
    .acc_in  (acc_reg),
    .sat     (sat_reg),
    .acc_sum (acc_sum),
    .result  (c_elem)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_CHECK;
      ST_CHECK: state_next = dim_bad ? ST_DONE : ST_MAC;
      ST_MAC:   if (last_k && last_j && last_i) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sat_reg   <= 1'b0;
      a_m_reg   <= '0;
      a_n_reg   <= '0;
      b_m_reg   <= '0;
      b_n_reg   <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      acc_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
      c_m_reg   <= '0;
      c_n_reg   <= '0;
      c_arr_reg <= '{default: '0};
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_reg     <= matrices_in[MAT_W-1:0];
            b_reg     <= matrices_in[2*MAT_W-1:MAT_W];
            sat_reg   <= sat;
            a_m_reg   <= a_m;
            a_n_reg   <= a_n;
            b_m_reg   <= b_m;
            b_n_reg   <= b_n;
            busy_reg  <= 1'b1;
            valid_reg <= 1'b0;
            error_reg <= 1'b0;
            c_m_reg   <= '0;
            c_n_reg   <= '0;
            c_arr_reg <= '{default: '0};
          end
        end
        ST_CHECK: begin
          if (dim_bad) begin
            error_reg <= 1'b1;
          end else begin
            c_m_reg <= a_m_reg;
            c_n_reg <= b_n_reg;
            acc_reg <= '0;
            i_reg   <= '0;
            j_reg   <= '0;
            k_reg   <= '0;
          end
        end
        ST_MAC: begin
          // The final product of a dot product goes straight to C, never through acc.
          if (last_k) begin
            c_arr_reg[c_idx] <= c_elem;
            acc_reg <= '0;
            k_reg   <= '0;
            if (last_j) begin
              j_reg <= '0;
              i_reg <= i_reg + DIM_ONE;
            end else begin
              j_reg <= j_reg + DIM_ONE;
            end
          end else begin
            acc_reg <= acc_sum;
            k_reg   <= k_reg + DIM_ONE;
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b1;
          valid_reg <= !error_reg;
          busy_reg  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign valid = valid_reg;
  assign error = error_reg;
  assign c_m   = c_m_reg;
  assign c_n   = c_n_reg;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench for matrix_mac_engine: hand-computed products, rejection,
// clamping modes, ignored start, input changes and reset mid-operation.
module tb_matrix_mac_engine;

  localparam int MAX_DIM = 5;
  localparam int ELEM_W  = 8;
  localparam int DIM_W   = 3;
  localparam int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;

  logic               clk = 1'b0;
  logic               reset, start, sat;
  logic [DIM_W-1:0]   a_m, a_n, b_m, b_n;
  logic [2*MAT_W-1:0] matrices_in;
  logic               busy, done, valid, error;
  logic [DIM_W-1:0]   c_m, c_n;
  logic [MAT_W-1:0]   matrices_out;

  int checks   = 0;
  int failures = 0;

  matrix_mac_engine #(
    .MAX_DIM (MAX_DIM),
    .ELEM_W  (ELEM_W),
    .DIM_W   (DIM_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sat          (sat),
    .a_m          (a_m),
    .a_n          (a_n),
    .b_m          (b_m),
    .b_n          (b_n),
    .matrices_in  (matrices_in),
    .busy         (busy),
    .done         (done),
    .valid        (valid),
    .error        (error),
    .c_m          (c_m),
    .c_n          (c_n),
    .matrices_out (matrices_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAT_W-1:0] set_el(input logic [MAT_W-1:0] m, input int r,
                                              input int c, input int v);
    logic [MAT_W-1:0] t;
    t = m;
    t[(r*MAX_DIM+c)*ELEM_W +: ELEM_W] = v[ELEM_W-1:0];
    return t;
  endfunction

  function automatic logic [MAT_W-1:0] fill(input int rows, input int cols, input int v);
    logic [MAT_W-1:0] t;
    t = '0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        t = set_el(t, r, c, v);
    return t;
  endfunction

  task automatic start_op(input int am, input int an, input int bm, input int bn, input logic s,
                          input logic [MAT_W-1:0] amat, input logic [MAT_W-1:0] bmat);
    int t;
    @(negedge clk);
    t = am; a_m = t[DIM_W-1:0];
    t = an; a_n = t[DIM_W-1:0];
    t = bm; b_m = t[DIM_W-1:0];
    t = bn; b_n = t[DIM_W-1:0];
    sat = s;
    matrices_in = {bmat, amat};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the start sampling edge until done; -1 if the budget runs out.
  task automatic wait_done(input int budget, input logic disturb, output int lat);
    lat = -1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clk);
      #1;
      if (disturb && cyc == 5) begin
        start = 1'b1;
        matrices_in = ~matrices_in;
        a_m = 3'd1; a_n = 3'd1; b_m = 3'd1; b_n = 3'd1;
        sat = ~sat;
      end
      if (disturb && cyc == 6) start = 1'b0;
      if (done) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input int am, input int an, input int bm, input int bn,
                        input logic s, input logic [MAT_W-1:0] amat, input logic [MAT_W-1:0] bmat,
                        input int exp_lat, input logic exp_err, input int exp_cm, input int exp_cn,
                        input logic [MAT_W-1:0] exp_out, input logic disturb);
    int lat;
    start_op(am, an, bm, bn, s, amat, bmat);
    check($sformatf("%s.busy_start", name), busy, 1);
    wait_done(300, disturb, lat);
    check($sformatf("%s.latency", name), lat, exp_lat);
    check($sformatf("%s.valid", name), valid, !exp_err);
    check($sformatf("%s.error", name), error, exp_err);
    check($sformatf("%s.c_m", name), c_m, exp_cm);
    check($sformatf("%s.c_n", name), c_n, exp_cn);
    check($sformatf("%s.out", name), matrices_out, exp_out);
    check($sformatf("%s.busy_end", name), busy, 0);
    @(posedge clk);
    #1;
    check($sformatf("%s.done_pulse", name), done, 0);
    $display("op %s: latency=%0d valid=%0b error=%0b c=%0dx%0d out=%0h",
             name, lat, valid, error, c_m, c_n, matrices_out);
  endtask

  logic [MAT_W-1:0] a23, b32, c22, all255, exp5, exp255, one200, exp64, exp_sat;
  int done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; sat = 1'b0;
    a_m = '0; a_n = '0; b_m = '0; b_n = '0; matrices_in = '0;

    a23 = '0;
    a23 = set_el(a23, 0, 0, 1); a23 = set_el(a23, 0, 1, 2); a23 = set_el(a23, 0, 2, 3);
    a23 = set_el(a23, 1, 0, 4); a23 = set_el(a23, 1, 1, 5); a23 = set_el(a23, 1, 2, 6);
    b32 = '0;
    b32 = set_el(b32, 0, 0, 7);  b32 = set_el(b32, 0, 1, 8);
    b32 = set_el(b32, 1, 0, 9);  b32 = set_el(b32, 1, 1, 10);
    b32 = set_el(b32, 2, 0, 11); b32 = set_el(b32, 2, 1, 12);
    c22 = '0;
    c22 = set_el(c22, 0, 0, 58);  c22 = set_el(c22, 0, 1, 64);
    c22 = set_el(c22, 1, 0, 139); c22 = set_el(c22, 1, 1, 154);
    all255  = fill(5, 5, 255);
    exp5    = fill(5, 5, 5);
    exp255  = fill(5, 5, 255);
    one200  = fill(1, 1, 200);
    exp64   = fill(1, 1, 64);
    exp_sat = fill(1, 1, 255);

    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.valid", valid, 0);
    check("reset.error", error, 0);
    check("reset.c_dims", {c_m, c_n}, 0);
    check("reset.out", matrices_out, 0);
    reset = 1'b0;

    run_op("mul2x3x2", 2, 3, 3, 2, 1'b0, a23, b32, 14, 1'b0, 2, 2, c22, 1'b0);
    run_op("one_trunc", 1, 1, 1, 1, 1'b0, one200, one200, 3, 1'b0, 1, 1, exp64, 1'b0);
    run_op("one_sat", 1, 1, 1, 1, 1'b1, one200, one200, 3, 1'b0, 1, 1, exp_sat, 1'b0);
    run_op("full_trunc", 5, 5, 5, 5, 1'b0, all255, all255, 127, 1'b0, 5, 5, exp5, 1'b0);
    run_op("full_sat", 5, 5, 5, 5, 1'b1, all255, all255, 127, 1'b0, 5, 5, exp255, 1'b0);
    run_op("mismatch", 2, 3, 2, 2, 1'b0, a23, b32, 2, 1'b1, 0, 0, '0, 1'b0);
    run_op("zero_dim", 0, 3, 3, 2, 1'b0, a23, b32, 2, 1'b1, 0, 0, '0, 1'b0);
    run_op("too_big", 6, 3, 3, 2, 1'b0, a23, b32, 2, 1'b1, 0, 0, '0, 1'b0);
    run_op("disturbed", 2, 3, 3, 2, 1'b0, a23, b32, 14, 1'b0, 2, 2, c22, 1'b1);

    // Abort a long operation with reset and confirm it leaves no trace.
    start_op(5, 5, 5, 5, 1'b0, all255, all255);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.valid", valid, 0);
    check("abort.error", error, 0);
    check("abort.c_dims", {c_m, c_n}, 0);
    check("abort.out", matrices_out, 0);
    reset = 1'b0;
    done_seen = 0;
    for (int cyc = 0; cyc < 140; cyc++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("abort.no_done", done_seen, 0);
    $display("op abort: reset mid-MAC, done/busy cycles afterwards=%0d", done_seen);

    run_op("after_abort", 2, 3, 3, 2, 1'b0, a23, b32, 14, 1'b0, 2, 2, c22, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_mac_engine.md
MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

Interface
REQ-001 SHALL provide parameter MAX_DIM, default 5, meaning the maximum rows/columns of any operand.
REQ-002 SHALL provide parameter ELEM_W, default 8, meaning the unsigned element width.
REQ-003 SHALL provide parameter DIM_W, default $clog2(MAX_DIM+1), meaning the dimension field width.
REQ-004 SHALL define local ACC_W = 2*ELEM_W + $clog2(MAX_DIM), meaning the accumulator width that cannot overflow.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 start  input  1  request a new operation; sampled in IDLE only.
REQ-009 sat  input  1  output mode: 0 = truncate to low ELEM_W bits, 1 = saturate to 2^ELEM_W-1.
REQ-010 a_m, a_n, b_m, b_n  input  DIM_W each  operand dimensions.
REQ-011 matrices_in  input  2*MAX_DIM*MAX_DIM*ELEM_W  A in lower half, B in upper half; element (r,c) at [(r*MAX_DIM+c)*ELEM_W +: ELEM_W].
REQ-012 busy  output  1  operation in progress.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 valid  output  1  result held on matrices_out is valid; held until the next accepted start.
REQ-015 error  output  1  last operation rejected; held until the next accepted start.
REQ-016 c_m, c_n  output  DIM_W each  result dimensions.
REQ-017 matrices_out  output  MAX_DIM*MAX_DIM*ELEM_W  result C, same element layout as A.

Function
REQ-018 States SHALL be IDLE, CHECK, MAC, DONE.
REQ-019 In IDLE with start=1, the block SHALL latch dimensions, matrices_in and sat; clear matrices_out, valid, error, c_m and c_n; assert busy; and go to CHECK.
REQ-020 CHECK SHALL reject the operation when any dimension is 0, any dimension exceeds MAX_DIM, or a_n != b_m; on rejection it sets error=1 and goes to DONE.
REQ-021 On acceptance, CHECK SHALL set c_m=a_m, c_n=b_n, clear the accumulator, set indices i=j=k=0, and go to MAC.
REQ-022 MAC SHALL perform exactly one product per cycle: acc += A[i][k]*B[k][j], with full ACC_W precision.
REQ-023 When k==a_n-1, MAC SHALL write C[i][j] in the same cycle using the latched sat mode (truncated or saturated), clear acc, and reset k to 0.
REQ-024 After each write, j SHALL advance; j wraps to 0 at b_n-1 and i then advances.
REQ-025 After writing C[a_m-1][b_n-1], MAC SHALL go to DONE.
REQ-026 DONE SHALL pulse done for one cycle, set valid=!error, deassert busy, and return to IDLE.
REQ-027 Accepted-operation latency SHALL be: done high exactly a_m*a_n*b_n+2 cycles after the start sampling edge; rejected operations SHALL pulse done 2 cycles after that edge.
REQ-028 Elements outside c_m x c_n SHALL read zero.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 Changes to inputs after acceptance SHALL NOT affect the result.
REQ-031 start in the cycle DONE is active SHALL NOT be accepted; it is accepted in the following IDLE cycle.

Reset
REQ-032 reset SHALL force IDLE and zero busy, done, valid, error, c_m, c_n, matrices_out, acc and the indices, from any state including mid-MAC; no done pulse is produced for the aborted operation.

Structure
REQ-033 Package matrix_pkg SHALL hold the MAX_DIM, ELEM_W and ACC_W defaults, the state encoding, and the element-index helper function.
REQ-034 The multiply-accumulate-and-clamp datapath SHALL be one sub-module, matrix_mac_cell.

Verification
REQ-035 2x3 A=[1,2,3;4,5,6] times 3x2 B=[7,8;9,10;11,12], sat=0 -> C=[58,64;139,154], c_m=2, c_n=2, valid=1, done 14 cycles after start.
REQ-036 a_n=3, b_m=2 -> error=1, valid=0, matrices_out all zero, done 2 cycles after start.
REQ-037 1x1 with 200*200: sat=0 -> 64; sat=1 -> 255.
REQ-038 5x5 all 255, sat=0 -> every element 5, done 127 cycles after start; repeat with sat=1 -> every element 255.
REQ-039 start pulsed mid-MAC with different operands -> ignored, first result unchanged; reset asserted mid-MAC -> all outputs 0 next cycle, no done pulse; next start completes normally.
